// File: rtl/div2c_frac_4bit.sv
// Sequential signed fractional divider: (2N-1)-bit Q1.(2N-2) dividend by an
// N-bit Q1.(N-1) divisor. Restoring division on magnitudes produces one
// quotient bit per clock. The remainder carries the sign of the dividend.
module div2c_frac_4bit #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 st,
    input  logic [2*N-2:0]       dividend,
    input  logic [N-1:0]         divisor,
    output logic [N-1:0]         quotient,
    output logic [N-1:0]         remainder,
    output logic                 ovf,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned DW = 2 * N - 1;
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_SHIFT,
        S_SIGN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DW-1:0]  r_dmag;
    logic [N-1:0]   r_vmag;
    logic           r_sd;
    logic           r_sv;
    logic [N-1:0]   r_prem;
    logic [N-2:0]   r_dlow;
    logic [N-2:0]   r_qmag;
    logic [CW-1:0]  r_cnt;

    logic [N-1:0]   r_quotient;
    logic [N-1:0]   r_remainder;
    logic           r_ovf;
    logic           r_busy;
    logic           r_done;

    logic [DW-1:0]  w_dmag;
    logic [N-1:0]   w_vmag;
    logic           w_ovf;
    logic [N:0]     w_trial;
    logic           w_ge;
    logic [N-1:0]   w_diff;
    logic [N-1:0]   w_qpos;
    logic           w_last;

    // Operand magnitudes; the most negative codes map onto 2^(DW-1) and 2^(N-1)
    // which still fit the unsigned registers.
    assign w_dmag = dividend[DW-1] ? DW'(-dividend) : dividend;
    assign w_vmag = divisor[N-1]   ? N'(-divisor)   : divisor;

    // Overflow when the divisor is zero or the quotient magnitude reaches 1.0.
    assign w_ovf = (r_vmag == '0) || (r_dmag >= {r_vmag, {(N-1){1'b0}}});

    // One restoring step: bring in the next dividend bit and trial-subtract.
    assign w_trial = {r_prem, r_dlow[N-2]};
    assign w_ge    = (w_trial >= {1'b0, r_vmag});
    assign w_diff  = N'(w_trial - {1'b0, r_vmag});
    assign w_qpos  = {1'b0, r_qmag};

    // CHECK performs the first step, SHIFT the remaining N-2 steps.
    assign w_last  = (r_cnt == CW'(N - 2));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (st) w_next = S_LOAD;
            S_LOAD:  w_next = S_CHECK;
            S_CHECK: w_next = w_ovf ? S_DONE : ((N == 2) ? S_SIGN : S_SHIFT);
            S_SHIFT: if (w_last) w_next = S_SIGN;
            S_SIGN:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture and restoring-division datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dmag <= '0;
            r_vmag <= '0;
            r_sd   <= 1'b0;
            r_sv   <= 1'b0;
            r_prem <= '0;
            r_dlow <= '0;
            r_qmag <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (st) begin
                        r_dmag <= w_dmag;
                        r_vmag <= w_vmag;
                        r_sd   <= dividend[DW-1];
                        r_sv   <= divisor[N-1];
                    end
                end
                S_LOAD: begin
                    r_prem <= r_dmag[DW-1:N-1];
                    r_dlow <= r_dmag[N-2:0];
                    r_qmag <= '0;
                    r_cnt  <= '0;
                end
                S_CHECK, S_SHIFT: begin
                    if (!(r_state == S_CHECK && w_ovf)) begin
                        r_prem <= w_ge ? w_diff : w_trial[N-1:0];
                        r_qmag <= (N-1)'({r_qmag, w_ge});
                        r_dlow <= r_dlow << 1;
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers update only on the transition into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_ovf       <= 1'b0;
        end else if (r_state == S_CHECK && w_ovf) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_ovf       <= 1'b1;
        end else if (r_state == S_SIGN) begin
            r_quotient  <= (r_sd ^ r_sv) ? N'(-w_qpos) : w_qpos;
            r_remainder <= r_sd ? N'(-r_prem) : r_prem;
            r_ovf       <= 1'b0;
        end
    end

    // Status flags registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign ovf       = r_ovf;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_div2c_frac_4bit.sv
// Self-checking bench for div2c_frac_4bit (N=4) with a gold-model scoreboard.
module tb_div2c_frac_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       st;
    logic [6:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       ovf;
    logic       busy;
    logic       done;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       o;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    div2c_frac_4bit #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .st        (st),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Gold model: truncating division, remainder takes the dividend's sign.
    function automatic exp_t model(input logic [6:0] dd, input logic [3:0] dv);
        exp_t e;
        int di, vi, ad, av, qq, rr;
        di = $signed(dd);
        vi = $signed(dv);
        ad = (di < 0) ? -di : di;
        av = (vi < 0) ? -vi : vi;
        if (vi == 0 || ad >= av * 8) begin
            e.q = 4'd0; e.r = 4'd0; e.o = 1'b1; e.lat = 2;
        end else begin
            qq = di / vi;
            rr = di - qq * vi;
            e.q = 4'(qq); e.r = 4'(rr); e.o = 1'b0; e.lat = 5;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one division, optionally poke st while busy, then score the result.
    task automatic run_op(input logic [6:0] dd, input logic [3:0] dv, input bit poke);
        exp_t e;
        int   g;
        int   lat;
        g = 0;
        @(negedge clk);
        while (busy !== 1'b0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk($sformatf("idle_before_st %h/%h", dd, dv), 32'(busy), 32'd0);
        dividend = dd;
        divisor  = dv;
        st       = 1'b1;
        sb.push_back(model(dd, dv));
        @(posedge clk);
        #1;
        st       = 1'b0;
        dividend = 7'($urandom);
        divisor  = 4'($urandom);
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (poke && c == 1) st = 1'b1;
            if (c == 2) st = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        e = sb.pop_front();
        chk($sformatf("latency %h/%h", dd, dv),   32'(lat),       32'(e.lat));
        chk($sformatf("quotient %h/%h", dd, dv),  32'(quotient),  32'(e.q));
        chk($sformatf("remainder %h/%h", dd, dv), 32'(remainder), 32'(e.r));
        chk($sformatf("ovf %h/%h", dd, dv),       32'(ovf),       32'(e.o));
        @(posedge clk);
        #1;
        chk($sformatf("done_one_cycle %h/%h", dd, dv), 32'(done), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst      = 1'b1;
        st       = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_quotient",  32'(quotient),  32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_ovf",       32'(ovf),       32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_done",      32'(done),      32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op(7'b0011001, 4'b0101, 1'b0);
        run_op(7'b1110001, 4'b0101, 1'b0);
        run_op(7'b1110001, 4'b1101, 1'b0);
        run_op(7'b0010111, 4'b0101, 1'b0);
        run_op(7'b1101001, 4'b0101, 1'b0);
        run_op(7'b0101000, 4'b0101, 1'b0);
        run_op(7'b0000001, 4'b0000, 1'b0);
        run_op(7'b1000000, 4'b1000, 1'b0);
        run_op(7'b0011001, 4'b0101, 1'b0);

        // Reset two edges into an operation.
        @(negedge clk);
        dividend = 7'b0010111;
        divisor  = 4'b0101;
        st       = 1'b1;
        @(posedge clk);
        #1;
        st = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_quotient",  32'(quotient),  32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        chk("abort_ovf",       32'(ovf),       32'd0);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_done",      32'(done),      32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        run_op(7'b0010111, 4'b0101, 1'b0);

        // Exhaustive sweep, back to back, with occasional st while busy.
        for (int dd = 0; dd < 128; dd++) begin
            for (int dv = 0; dv < 16; dv++) begin
                run_op(7'(dd), 4'(dv), ((dd * 16 + dv) % 37) == 0);
            end
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
